// File: rtl/mole_pkg.sv
// Shared constants, level encodings and FSM state type for the mole spawner.
package mole_pkg;

  localparam int unsigned NUM_LEDS_DEF = 18;

  typedef logic [2:0] level_t;

  localparam level_t LVL_EASY   = 3'b000;
  localparam level_t LVL_MED    = 3'b001;
  localparam level_t LVL_HARD   = 3'b010;
  localparam level_t LVL_EXPERT = 3'b100;

  localparam logic [15:0] WIN_EASY_MS   = 16'd2000;
  localparam logic [15:0] WIN_MED_MS    = 16'd1500;
  localparam logic [15:0] WIN_HARD_MS   = 16'd1000;
  localparam logic [15:0] WIN_EXPERT_MS = 16'd700;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    ARMED,
    WINDOW,
    EXPIRED
  } spawn_state_t;

  // Unknown level codes fall back to the most forgiving window.
  function automatic logic [15:0] window_ms(input level_t lvl);
    case (lvl)
      LVL_MED:    return WIN_MED_MS;
      LVL_HARD:   return WIN_HARD_MS;
      LVL_EXPERT: return WIN_EXPERT_MS;
      default:    return WIN_EASY_MS;
    endcase
  endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Handshake between the whac-a-mole game FSM (master) and the mole spawner (slave).
interface mole_spawner_if #(
  parameter int unsigned NUM_LEDS = mole_pkg::NUM_LEDS_DEF
) ();

  logic                ready_for_mole;
  logic                timeout_start;
  logic [2:0]          level_select;
  logic [NUM_LEDS-1:0] led_number;
  logic                rng_ready;
  logic                timeout;
  logic [15:0]         time_left_ms;

  modport master (
    output ready_for_mole, timeout_start, level_select,
    input  led_number, rng_ready, timeout, time_left_ms
  );

  modport slave (
    input  ready_for_mole, timeout_start, level_select,
    output led_number, rng_ready, timeout, time_left_ms
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
module lfsr16 #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] q_d;

  assign q_d = {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= Seed;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Mole position picker and reaction-window timer for the whac-a-mole FSM.
// Define MOLE_NO_REPEAT_EN to forbid two consecutive moles on the same LED.
module mole_spawner
  import mole_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = NUM_LEDS_DEF,
  parameter int unsigned TICK_DIV  = 50_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic           clk,
  input logic           rst_n,
  mole_spawner_if.slave spawn_if
);

  localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  spawn_state_t        state_q, state_d;
  logic [15:0]         lfsr_q;
  logic [1:0]          armed_cnt_q, armed_cnt_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [15:0]         time_left_q, time_left_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                rng_ready_q, rng_ready_d;
  logic                timeout_q, timeout_d;
  logic                tick, last_tick;
  logic [4:0]          raw_idx, red_idx, pick_idx;
  logic                unused_lfsr_hi;

  lfsr16 #(
    .Seed(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[15:5];
  assign raw_idx = lfsr_q[4:0];
  assign red_idx = (raw_idx >= 5'(NUM_LEDS)) ? raw_idx - 5'(NUM_LEDS) : raw_idx;

`ifdef MOLE_NO_REPEAT_EN
  logic [4:0] last_idx_q, last_idx_d;

  assign pick_idx = (red_idx != last_idx_q)        ? red_idx :
                    (red_idx == 5'(NUM_LEDS - 1)) ? 5'd0    : red_idx + 5'd1;
`else
  assign pick_idx = red_idx;
`endif

  assign tick      = (presc_q == '0);
  assign last_tick = tick && (time_left_q == 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      armed_cnt_q <= '0;
      presc_q     <= '0;
      time_left_q <= '0;
      led_q       <= '0;
      rng_ready_q <= 1'b0;
      timeout_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      armed_cnt_q <= armed_cnt_d;
      presc_q     <= presc_d;
      time_left_q <= time_left_d;
      led_q       <= led_d;
      rng_ready_q <= rng_ready_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef MOLE_NO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx_q <= 5'(NUM_LEDS);
    end else begin
      last_idx_q <= last_idx_d;
    end
  end
`endif

  // A falling timeout_start always wins over a simultaneous expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (spawn_if.ready_for_mole) state_d = PICK;
      PICK:    state_d = spawn_if.ready_for_mole ? ARMED : IDLE;
      ARMED: begin
        if (spawn_if.timeout_start) state_d = WINDOW;
        else if (armed_cnt_q == 2'd3) state_d = IDLE;
      end
      WINDOW: begin
        if (!spawn_if.timeout_start) state_d = IDLE;
        else if (last_tick) state_d = EXPIRED;
      end
      EXPIRED: if (!spawn_if.timeout_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    armed_cnt_d = '0;
    presc_d     = '0;
    time_left_d = '0;
    led_d       = led_q;
    rng_ready_d = 1'b0;
`ifdef MOLE_NO_REPEAT_EN
    last_idx_d  = last_idx_q;
`endif
    unique case (state_q)
      PICK: begin
        if (spawn_if.ready_for_mole) begin
          led_d       = {{(NUM_LEDS - 1){1'b0}}, 1'b1} << pick_idx;
          rng_ready_d = 1'b1;
`ifdef MOLE_NO_REPEAT_EN
          last_idx_d  = pick_idx;
`endif
        end
      end
      ARMED: begin
        if (spawn_if.timeout_start) begin
          presc_d     = PrescMax;
          time_left_d = window_ms(spawn_if.level_select);
        end else begin
          armed_cnt_d = armed_cnt_q + 2'd1;
        end
      end
      WINDOW: begin
        if (spawn_if.timeout_start && !last_tick) begin
          presc_d     = tick ? PrescMax : presc_q - 1'b1;
          time_left_d = tick ? time_left_q - 16'd1 : time_left_q;
        end
      end
      default: ;
    endcase
    timeout_d = (state_d != EXPIRED);
  end

  assign spawn_if.led_number   = led_q;
  assign spawn_if.rng_ready    = rng_ready_q;
  assign spawn_if.timeout      = timeout_q;
  assign spawn_if.time_left_ms = time_left_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: predicted mole positions are queued at request
// time and popped on rng_ready; window scenarios come from a vector table.
module tb_mole_spawner;

  localparam int unsigned NLeds = 18;
  localparam int unsigned Tick  = 4;
  localparam logic [15:0] Seed  = 16'hACE1;

  typedef struct {
    logic [2:0] lvl;
    logic [2:0] lvl_mid;
    int         drop_cyc;
    int         exp_ms;
  } win_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mole_spawner_if #(.NUM_LEDS(NLeds)) bus ();

  mole_spawner #(
    .NUM_LEDS (NLeds),
    .TICK_DIV (Tick),
    .LFSR_SEED(Seed)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spawn_if(bus)
  );

  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_errors = 0;
  int             exp_q[$];
  logic [15:0]    m_lfsr;
  int             m_last;
  logic [NLeds-1:0] exp_led;
  logic [NLeds-1:0] prev_led;
  logic [NLeds-1:0] cover_mask;
  win_vec_t       vecs[8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= Seed;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int model_pick(input logic [15:0] v);
    int r;
    r = int'(v[4:0]);
    if (r >= NLeds) r = r - NLeds;
`ifdef MOLE_NO_REPEAT_EN
    if (r == m_last) r = (r + 1) % NLeds;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  // Leaves the DUT just after the PICK edge with ready_for_mole low again.
  task automatic spawn();
    int idx;
    idx = model_pick(lfsr_next(m_lfsr));
    m_last = idx;
    exp_q.push_back(idx);
    bus.ready_for_mole = 1'b1;
    tick1();
    chk("rdy_early", bus.rng_ready, 0);
    tick1();
    chk("rdy_pulse", bus.rng_ready, 1);
    if (bus.rng_ready && exp_q.size() > 0) begin
      idx = exp_q.pop_front();
      exp_led = '0;
      exp_led[idx] = 1'b1;
      chk("led_number", bus.led_number, exp_led);
`ifdef MOLE_NO_REPEAT_EN
      cover_mask = cover_mask | bus.led_number;
      chk("no_repeat", (bus.led_number == prev_led), 0);
      prev_led = bus.led_number;
`endif
    end
    bus.ready_for_mole = 1'b0;
  endtask

  initial begin
    int e_cyc, last, fall, cnt_rdy, cnt_lo;

    vecs[0] = '{lvl: 3'b100, lvl_mid: 3'b100, drop_cyc: 1200, exp_ms: 700};
    vecs[1] = '{lvl: 3'b010, lvl_mid: 3'b010, drop_cyc: 4000, exp_ms: 1000};
    vecs[2] = '{lvl: 3'b001, lvl_mid: 3'b001, drop_cyc: 5999, exp_ms: 1500};
    vecs[3] = '{lvl: 3'b000, lvl_mid: 3'b000, drop_cyc: 0,    exp_ms: 2000};
    vecs[4] = '{lvl: 3'b001, lvl_mid: 3'b100, drop_cyc: 0,    exp_ms: 1500};
    vecs[5] = '{lvl: 3'b010, lvl_mid: 3'b010, drop_cyc: 0,    exp_ms: 1000};
    vecs[6] = '{lvl: 3'b100, lvl_mid: 3'b000, drop_cyc: 0,    exp_ms: 700};
    vecs[7] = '{lvl: 3'b101, lvl_mid: 3'b101, drop_cyc: 0,    exp_ms: 2000};

    bus.ready_for_mole = 1'b0;
    bus.timeout_start  = 1'b0;
    bus.level_select   = 3'b000;
    ticks(3);
    chk("rst_led", bus.led_number, 0);
    chk("rst_rdy", bus.rng_ready, 0);
    chk("rst_timeout", bus.timeout, 1);
    chk("rst_time_left", bus.time_left_ms, 0);
    rst_n = 1'b1;
    m_last = NLeds;
    prev_led = '0;
    cover_mask = '0;
    tick1();
    chk("idle_timeout", bus.timeout, 1);

    for (int n = 0; n < 200; n++) begin
      spawn();
      tick1();
      chk("rdy_width", bus.rng_ready, 0);
      ticks(3 + int'($urandom_range(0, 3)));
    end
`ifdef MOLE_NO_REPEAT_EN
    chk("all_indices", cover_mask, {NLeds{1'b1}});
`endif

    // ready_for_mole withdrawn while in PICK: no pulse, no pick
    bus.ready_for_mole = 1'b1;
    tick1();
    bus.ready_for_mole = 1'b0;
    tick1();
    chk("abort_rdy0", bus.rng_ready, 0);
    tick1();
    chk("abort_rdy1", bus.rng_ready, 0);

    for (int i = 0; i < 8; i++) begin
      spawn();
      bus.level_select  = vecs[i].lvl;
      bus.timeout_start = 1'b1;
      tick1();
      chk($sformatf("v%0d_load", i), bus.time_left_ms, vecs[i].exp_ms);
      bus.level_select = vecs[i].lvl_mid;
      e_cyc = vecs[i].exp_ms * Tick;
      last  = (vecs[i].drop_cyc != 0) ? vecs[i].drop_cyc + 1 : e_cyc + 1;
      fall  = -1;
      for (int c = 1; c <= last; c++) begin
        tick1();
        if (c == Tick) chk($sformatf("v%0d_first_ms", i), bus.time_left_ms, vecs[i].exp_ms - 1);
        if (vecs[i].drop_cyc == 0 && c == e_cyc - 1)
          chk($sformatf("v%0d_last_ms", i), bus.time_left_ms, 1);
        if (!bus.timeout && fall < 0) fall = c;
        if (vecs[i].drop_cyc != 0 && c == vecs[i].drop_cyc - 1) bus.timeout_start = 1'b0;
      end
      if (vecs[i].drop_cyc == 0) begin
        chk($sformatf("v%0d_expiry_cycle", i), fall, e_cyc);
        chk($sformatf("v%0d_expired_tl", i), bus.time_left_ms, 0);
        ticks(3);
        chk($sformatf("v%0d_hold_low", i), bus.timeout, 0);
        bus.timeout_start = 1'b0;
        tick1();
        chk($sformatf("v%0d_release", i), bus.timeout, 1);
      end else begin
        chk($sformatf("v%0d_hit_no_fall", i), fall, -1);
        chk($sformatf("v%0d_hit_tl", i), bus.time_left_ms, 0);
        chk($sformatf("v%0d_hit_timeout", i), bus.timeout, 1);
      end
      chk($sformatf("v%0d_led_hold", i), bus.led_number, exp_led);
      tick1();
    end

    // timeout_start first seen on the 4th ARMED edge still opens the window
    spawn();
    ticks(3);
    bus.level_select  = 3'b010;
    bus.timeout_start = 1'b1;
    tick1();
    chk("armed_late_load", bus.time_left_ms, 1000);
    bus.timeout_start = 1'b0;
    tick1();
    chk("armed_late_hit", bus.time_left_ms, 0);

    // one edge later ARMED has given up
    spawn();
    ticks(4);
    bus.timeout_start = 1'b1;
    tick1();
    chk("armed_gave_up", bus.time_left_ms, 0);
    ticks(2);
    chk("armed_gave_up_to", bus.timeout, 1);
    bus.timeout_start = 1'b0;
    tick1();

    // asynchronous reset in the middle of a window
    spawn();
    bus.level_select  = 3'b000;
    bus.timeout_start = 1'b1;
    ticks(50);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_led", bus.led_number, 0);
    chk("rstmid_rdy", bus.rng_ready, 0);
    chk("rstmid_timeout", bus.timeout, 1);
    chk("rstmid_time_left", bus.time_left_ms, 0);
    tick1();
    rst_n = 1'b1;
    m_last = NLeds;
    prev_led = '0;
    cnt_rdy = 0;
    cnt_lo = 0;
    for (int c = 0; c < 20; c++) begin
      tick1();
      if (bus.rng_ready) cnt_rdy++;
      if (!bus.timeout) cnt_lo++;
    end
    chk("rstmid_no_rdy", cnt_rdy, 0);
    chk("rstmid_no_expiry", cnt_lo, 0);
    chk("rstmid_idle_tl", bus.time_left_ms, 0);
    bus.timeout_start = 1'b0;
    tick1();
    spawn();
    ticks(5);

    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
